fetch_queue: RTL and testbench

//   Instruction fetch stage and fetch queue directly upstream of decode. Issues one

---
 rtl/fetch_queue.sv | 125 ++++++++++++
 tb/tb_fetch_queue.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch stage plus {pc, inst} queue feeding decode. One bus request in flight at a time;
// fetch parks after control/system instructions until execute redirects.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_valid,
    input  logic [31:0] iresp_data,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [63:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        out_ready,
    output logic [1:0]  dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

    state_t            state;
    state_t            state_next;
    logic [63:0]       pc;
    logic [63:0]       drain_addr;
    logic [63:0]       redirect_aligned;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W:0]    count;
    logic [63:0]       mem_pc   [DEPTH];
    logic [31:0]       mem_inst [DEPTH];
    logic              push;
    logic              pop;
    logic              flush;
    logic              is_ctrl;

    assign redirect_aligned = redirect_pc & ~64'd3;

    always_comb begin
        case (iresp_data[6:0])
            7'b1100011, 7'b1101111, 7'b1100111, 7'b1110011: is_ctrl = 1'b1;
            default:                                        is_ctrl = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Entering REQ requires a free slot, so the eventual push can never overflow.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!redirect && count < DEPTH_CNT) state_next = REQ;
            REQ: begin
                if (redirect)         state_next = iresp_valid ? IDLE : DRAIN;
                else if (iresp_valid) state_next = is_ctrl ? HOLD : IDLE;
            end
            HOLD:  if (redirect)    state_next = IDLE;
            DRAIN: if (iresp_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ireq_valid = (state == REQ) || (state == DRAIN);
        ireq_addr  = (state == DRAIN) ? drain_addr : pc;
        dbg_state  = state;
    end

    // Decode handshake: an entry transfers on any cycle where out_valid && out_ready.
    assign push  = (state == REQ) && iresp_valid && !redirect;
    assign flush = redirect && (state != DRAIN);
    assign pop   = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= PC_RESET;
            drain_addr <= PC_RESET;
        end else begin
            if (redirect)  pc <= redirect_aligned;
            else if (push) pc <= pc + 64'd4;
            // The abandoned request must stay on the bus until its response returns.
            if (state == REQ && redirect && !iresp_valid) drain_addr <= pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[tail]   <= pc;
            mem_inst[tail] <= iresp_data;
        end
    end

    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? mem_pc[head]   : 64'd0;
    assign out_inst  = out_valid ? mem_inst[head] : 32'd0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic, all checked against
// a transaction-level model (expected-entry queue plus expected next fetch address).
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] PC_RESET = 64'h8000_0000;
    localparam logic [31:0] ADDI     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_valid = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready = 1'b0;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .PC_RESET(PC_RESET)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_valid(iresp_valid), .iresp_data(iresp_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_ready(out_ready), .dbg_state(dbg_state)
    );

    int total = 0;
    int bad = 0;

    // Model: queued {pc, inst}, next fetch pc, and the single outstanding request.
    logic [95:0] exp_q[$];
    logic [63:0] model_pc;
    logic [63:0] req_addr;
    bit          outstanding;
    bit          disc;
    bit          hold;
    int          lat;
    int          req_count = 0;

    logic        obs_iv;
    logic        obs_ov;
    logic [63:0] obs_ia;
    logic [63:0] obs_op;
    logic [31:0] obs_oi;

    function automatic bit ctrl_op(logic [31:0] w);
        case (w[6:0])
            7'h63, 7'h6F, 7'h67, 7'h73: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_pc    = PC_RESET;
        outstanding = 1'b0;
        disc        = 1'b0;
        hold        = 1'b0;
        lat         = 0;
    endtask

    // Called at posedge+1: sample outputs and compare them with the model.
    task automatic observe();
        logic [95:0] h;
        obs_iv = ireq_valid;
        obs_ia = ireq_addr;
        obs_ov = out_valid;
        obs_op = out_pc;
        obs_oi = out_inst;
        check("out_valid", obs_ov, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            h = exp_q[0];
            check("out_pc", obs_op, h[95:32]);
            check("out_inst", obs_oi, h[31:0]);
        end
        if (hold) check("hold_no_req", obs_iv, 1'b0);
        if (obs_iv && !outstanding) begin
            check("req_addr", obs_ia, model_pc);
            check("req_room", exp_q.size() < DEPTH, 1'b1);
            outstanding = 1'b1;
            disc        = 1'b0;
            req_addr    = obs_ia;
            lat         = $urandom_range(0, 3);
            req_count++;
        end
        check("req_held", obs_iv, outstanding);
        if (outstanding) check("req_stable", obs_ia, req_addr);
    endtask

    // Apply inputs for this cycle, advance the model across the edge, move to posedge+1.
    task automatic drive(bit rsp, logic [31:0] d, bit rdr, logic [63:0] rpc, bit rdy);
        iresp_valid = rsp;
        iresp_data  = d;
        redirect    = rdr;
        redirect_pc = rpc;
        out_ready   = rdy;
        if (obs_ov && rdy) void'(exp_q.pop_front());
        if (rdr) begin
            exp_q.delete();
            model_pc = rpc & ~64'd3;
            hold     = 1'b0;
            if (outstanding) begin
                if (rsp) outstanding = 1'b0;
                else     disc = 1'b1;
            end
        end else if (rsp && outstanding) begin
            outstanding = 1'b0;
            if (!disc) begin
                exp_q.push_back({req_addr, d});
                model_pc = req_addr + 64'd4;
                hold     = ctrl_op(d);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick(bit rsp, logic [31:0] d, bit rdr, logic [63:0] rpc, bit rdy);
        observe();
        drive(rsp, d, rdr, rpc, rdy);
    endtask

    task automatic wait_req(int start, logic [63:0] exp_addr, string tag, bit rdy);
        bit found;
        for (int n = 0; n < 30 && req_count == start; n++) begin
            observe();
            drive(1'b0, 32'h0, 1'b0, 64'h0, rdy);
        end
        found = (req_count != start);
        check({tag, "_seen"}, found, 1'b1);
        if (found) check(tag, req_addr, exp_addr);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        iresp_valid = 1'b0;
        redirect = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_ireq_valid", ireq_valid, 1'b0);
        check("rst_ireq_addr", ireq_addr, PC_RESET);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pc", out_pc, 64'h0);
        check("rst_out_inst", out_inst, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_release_idle", ireq_valid, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int start;
        bit rsp;
        bit rdr;
        logic [31:0] w;
        logic [63:0] rpc;

        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset values, first request on the second cycle after release.
        do_reset();
        observe();
        check("t1_req_valid", obs_iv, 1'b1);
        check("t1_req_addr", obs_ia, PC_RESET);
        drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);

        // Fill the queue with decode stalled, then drain it in order.
        for (int k = 0; k < 20; k++) tick(1'b1, ADDI | (32'(k) << 20), 1'b0, 64'h0, 1'b0);
        observe();
        check("t2_full_no_req", obs_iv, 1'b0);
        check("t2_full_valid", obs_ov, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
        start = req_count;
        for (int i = 0; i < 4; i++) begin
            observe();
            check("t2_pop_pc", obs_op, PC_RESET + 64'(4 * i));
            drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
        end
        wait_req(start, PC_RESET + 64'h10, "t2_resume", 1'b0);

        // Branch parks fetch until execute redirects.
        do_reset();
        tick(1'b1, ADDI, 1'b0, 64'h0, 1'b0);
        start = req_count;
        wait_req(start, PC_RESET + 64'h4, "t3_req1", 1'b0);
        tick(1'b1, 32'h0000_0463, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            observe();
            check("t3_hold", obs_iv, 1'b0);
            drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
        end
        tick(1'b0, 32'h0, 1'b1, 64'h8000_0100, 1'b0);
        start = req_count;
        wait_req(start, 64'h8000_0100, "t3_redirect", 1'b0);

        // Redirect with a request in flight: late response is dropped.
        tick(1'b0, 32'h0, 1'b1, 64'h9000_0000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            observe();
            check("t4_drain_valid", obs_iv, 1'b1);
            check("t4_drain_addr", obs_ia, 64'h8000_0100);
            drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
        end
        tick(1'b1, ADDI, 1'b0, 64'h0, 1'b0);
        start = req_count;
        observe();
        check("t4_discarded", obs_ov, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
        wait_req(start, 64'h9000_0000, "t4_refetch", 1'b0);

        // Redirect, response and pop in the same cycle.
        tick(1'b1, ADDI, 1'b0, 64'h0, 1'b0);
        start = req_count;
        wait_req(start, 64'h9000_0004, "t5_req", 1'b0);
        observe();
        check("t5_pop_pending", obs_ov, 1'b1);
        drive(1'b1, ADDI, 1'b1, 64'h9000_1000, 1'b1);
        observe();
        check("t5_flushed", obs_ov, 1'b0);
        check("t5_idle", obs_iv, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
        observe();
        check("t5_req_valid", obs_iv, 1'b1);
        check("t5_req_addr", obs_ia, 64'h9000_1000);
        drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);

        // Asynchronous reset with two entries queued and a request in flight.
        tick(1'b1, ADDI, 1'b0, 64'h0, 1'b0);
        start = req_count;
        wait_req(start, 64'h9000_1004, "t6_req1", 1'b0);
        tick(1'b1, ADDI, 1'b0, 64'h0, 1'b0);
        start = req_count;
        wait_req(start, 64'h9000_1008, "t6_req2", 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_req", ireq_valid, 1'b0);
        check("t6_async_out", out_valid, 1'b0);
        iresp_valid = 1'b0;
        redirect = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        observe();
        check("t6_refetch_valid", obs_iv, 1'b1);
        check("t6_refetch_addr", obs_ia, PC_RESET);
        drive(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);

        // Random traffic: variable latency, random pops, stray responses, redirects.
        start = req_count;
        for (int c = 0; c < 3000; c++) begin
            observe();
            if (outstanding) begin
                rsp = (lat == 0);
                if (lat > 0) lat--;
            end else begin
                rsp = ($urandom_range(0, 9) == 0);
            end
            w = $urandom;
            case ($urandom_range(0, 11))
                0:       w[6:0] = 7'h63;
                1:       w[6:0] = 7'h6F;
                2:       w[6:0] = 7'h67;
                3:       w[6:0] = 7'h73;
                default: w[6:0] = 7'h13;
            endcase
            rdr = hold ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
            rpc = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rpc[63:8] = '1;
            drive(rsp, w, rdr, rpc, $urandom_range(0, 1) == 1);
        end
        check("rand_progress", (req_count - start) > 200, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
